// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single RAM. One transaction at a time moves
// through IDLE -> ISSUE -> WAIT -> DONE. A watchdog ends a transaction with an error flag if
// the RAM never answers.
module ram_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter int unsigned TO_WIDTH       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  // Requester 0
  input  logic [ADDR_WIDTH-1:0] p0_address,
  input  logic [DATA_WIDTH-1:0] p0_write_data,
  input  logic                  p0_read_enable,
  input  logic                  p0_write_enable,
  output logic [DATA_WIDTH-1:0] p0_read_data,
  output logic                  p0_ready,
  output logic                  p0_error,
  // Requester 1
  input  logic [ADDR_WIDTH-1:0] p1_address,
  input  logic [DATA_WIDTH-1:0] p1_write_data,
  input  logic                  p1_read_enable,
  input  logic                  p1_write_enable,
  output logic [DATA_WIDTH-1:0] p1_read_data,
  output logic                  p1_ready,
  output logic                  p1_error,
  // RAM side
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_write_data,
  output logic                  ram_read_enable,
  output logic                  ram_write_enable,
  input  logic [DATA_WIDTH-1:0] ram_read_data,
  input  logic                  ram_ready,
  output logic                  busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  localparam logic [TO_WIDTH-1:0] WdLast = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  grant_q, grant_d;
  logic                  op_write_q, op_write_d;
  logic [TO_WIDTH-1:0]   wd_q, wd_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic                  ram_re_q, ram_re_d;
  logic                  ram_we_q, ram_we_d;
  logic [DATA_WIDTH-1:0] p0_rd_q, p0_rd_d;
  logic [DATA_WIDTH-1:0] p1_rd_q, p1_rd_d;
  logic [1:0]            ready_q, ready_d;
  logic [1:0]            error_q, error_d;
  logic                  busy_q, busy_d;

  logic [1:0] req;
  logic       gnt;

  assign req = {p1_read_enable | p1_write_enable, p0_read_enable | p0_write_enable};

  // Next-state logic: arbitration, latching of the granted request, watchdog and completion.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    op_write_d   = op_write_q;
    wd_d         = wd_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    ram_re_d     = ram_re_q;
    ram_we_d     = ram_we_q;
    p0_rd_d      = p0_rd_q;
    p1_rd_d      = p1_rd_q;
    ready_d      = 2'b00;
    error_d      = 2'b00;
    gnt          = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req != 2'b00) begin
          // Under contention the port that did not win last time is served.
          gnt          = (req == 2'b11) ? ~last_grant_q : req[1];
          state_d      = StIssue;
          grant_d      = gnt;
          last_grant_d = gnt;
          ram_addr_d   = gnt ? p1_address    : p0_address;
          ram_wdata_d  = gnt ? p1_write_data : p0_write_data;
          // Write wins when both enables are high.
          op_write_d   = gnt ? p1_write_enable : p0_write_enable;
          ram_we_d     = op_write_d;
          ram_re_d     = ~op_write_d;
        end
      end
      StIssue: begin
        ram_re_d = 1'b0;
        ram_we_d = 1'b0;
        wd_d     = '0;
        state_d  = StWait;
      end
      StWait: begin
        if (ram_ready) begin
          ready_d[grant_q] = 1'b1;
          if (!op_write_q) begin
            if (grant_q) p1_rd_d = ram_read_data;
            else         p0_rd_d = ram_read_data;
          end
          state_d = StDone;
        end else if (wd_q == WdLast) begin
          ready_d[grant_q] = 1'b1;
          error_d[grant_q] = 1'b1;
          if (grant_q) p1_rd_d = '0;
          else         p0_rd_d = '0;
          state_d = StDone;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      StDone: begin
        // One dead cycle so a request dropped on the ready edge is never re-granted.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  // State and output registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      op_write_q   <= 1'b0;
      wd_q         <= '0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      ram_re_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      p0_rd_q      <= '0;
      p1_rd_q      <= '0;
      ready_q      <= 2'b00;
      error_q      <= 2'b00;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      op_write_q   <= op_write_d;
      wd_q         <= wd_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      ram_re_q     <= ram_re_d;
      ram_we_q     <= ram_we_d;
      p0_rd_q      <= p0_rd_d;
      p1_rd_q      <= p1_rd_d;
      ready_q      <= ready_d;
      error_q      <= error_d;
      busy_q       <= busy_d;
    end
  end

  assign p0_read_data     = p0_rd_q;
  assign p1_read_data     = p1_rd_q;
  assign p0_ready         = ready_q[0];
  assign p1_ready         = ready_q[1];
  assign p0_error         = error_q[0];
  assign p1_error         = error_q[1];
  assign ram_address      = ram_addr_q;
  assign ram_write_data   = ram_wdata_q;
  assign ram_read_enable  = ram_re_q;
  assign ram_write_enable = ram_we_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios followed by randomized traffic from both ports
// checked against a transaction-level memory model.
module tb_ram_arbiter;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 15;

  logic          clk, rst;
  logic [AW-1:0] p0_address, p1_address;
  logic [DW-1:0] p0_write_data, p1_write_data;
  logic          p0_read_enable, p0_write_enable, p1_read_enable, p1_write_enable;
  logic [DW-1:0] p0_read_data, p1_read_data;
  logic          p0_ready, p0_error, p1_ready, p1_error;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_write_data;
  logic          ram_read_enable, ram_write_enable;
  logic [DW-1:0] ram_read_data;
  logic          ram_ready;
  logic          busy;
  logic          ram_dead;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] mem       [256];
  logic [DW-1:0] model_mem [256];

  ram_arbiter #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO),
    .TO_WIDTH      (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .p0_address      (p0_address),
    .p0_write_data   (p0_write_data),
    .p0_read_enable  (p0_read_enable),
    .p0_write_enable (p0_write_enable),
    .p0_read_data    (p0_read_data),
    .p0_ready        (p0_ready),
    .p0_error        (p0_error),
    .p1_address      (p1_address),
    .p1_write_data   (p1_write_data),
    .p1_read_enable  (p1_read_enable),
    .p1_write_enable (p1_write_enable),
    .p1_read_data    (p1_read_data),
    .p1_ready        (p1_ready),
    .p1_error        (p1_error),
    .ram_address     (ram_address),
    .ram_write_data  (ram_write_data),
    .ram_read_enable (ram_read_enable),
    .ram_write_enable(ram_write_enable),
    .ram_read_data   (ram_read_data),
    .ram_ready       (ram_ready),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM stub: answers one cycle after an enable unless ram_dead; contents reinit on reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= DW'(i * 10);
      ram_ready     <= 1'b0;
      ram_read_data <= '0;
    end else begin
      ram_ready <= !ram_dead && (ram_read_enable || ram_write_enable);
      if (ram_read_enable) ram_read_data <= mem[ram_address[7:0]];
      if (ram_write_enable) mem[ram_address[7:0]] <= ram_write_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int p, input logic re, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    if (p == 0) begin
      p0_read_enable = re; p0_write_enable = we; p0_address = a; p0_write_data = d;
    end else begin
      p1_read_enable = re; p1_write_enable = we; p1_address = a; p1_write_data = d;
    end
  endtask

  // Raise a request in an idle cycle, hold until ready (bounded), then drop it.
  task automatic do_txn(input int p, input logic re, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output logic [DW-1:0] rd, output logic err,
                        output int lat);
    logic got;
    got = 1'b0;
    rd  = '0;
    err = 1'b0;
    lat = 0;
    @(negedge clk);
    set_req(p, re, we, a, d);
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if ((p == 0) ? p0_ready : p1_ready) begin
        got = 1'b1;
        rd  = (p == 0) ? p0_read_data : p1_read_data;
        err = (p == 0) ? p0_error : p1_error;
      end
    end
    set_req(p, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [DW-1:0] rd;
    logic          err;
    int            lat;
    int            order [4];
    int            n;
    logic          saw;
    // Random-phase requester state.
    logic          act [2];
    int            rlat [2];
    int            gap [2];
    logic          op_w [2];
    logic [AW-1:0] ad [2];
    logic [DW-1:0] wd [2];
    logic [DW-1:0] exp_rd [2];
    logic          prev_en, cur_en, rdy;
    int            r;

    rst      = 1'b1;
    ram_dead = 1'b0;
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 256; i++) model_mem[i] = DW'(i * 10);

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ram_re", ram_read_enable, 0);
    check("rst_ram_we", ram_write_enable, 0);
    check("rst_ram_addr", ram_address, 0);
    check("rst_p0_ready", p0_ready, 0);
    check("rst_p1_error", p1_error, 0);
    check("rst_p0_rdata", p0_read_data, 0);
    rst = 1'b0;

    // Contention: both ports read continuously; first grant goes to p0, then alternate.
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 16'd1, '0);
    set_req(1, 1'b1, 1'b0, 16'd2, '0);
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      if (p0_ready) begin
        order[n] = 0; n++;
        check("rr_p0_data", p0_read_data, 32'd10);
      end
      if (p1_ready) begin
        order[n] = 1; n++;
        check("rr_p1_data", p1_read_data, 32'd20);
      end
    end
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    check("rr_count", n, 4);
    for (int i = 0; i < n; i++) check("rr_order", order[i], i % 2);
    repeat (3) @(negedge clk);

    // Single read with cycle-exact latency.
    set_req(0, 1'b1, 1'b0, 16'd5, '0);
    @(negedge clk);
    check("rd5_ram_re", ram_read_enable, 1);
    check("rd5_ram_we", ram_write_enable, 0);
    check("rd5_ram_addr", ram_address, 5);
    check("rd5_busy", busy, 1);
    @(negedge clk);
    check("rd5_ram_re_drop", ram_read_enable, 0);
    check("rd5_ready_early", p0_ready, 0);
    @(negedge clk);
    check("rd5_ready", p0_ready, 1);
    check("rd5_data", p0_read_data, 32'd50);
    check("rd5_error", p0_error, 0);
    check("rd5_p1_ready", p1_ready, 0);
    set_req(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("rd5_ready_pulse", p0_ready, 0);
    check("rd5_busy_done", busy, 0);
    check("rd5_data_hold", p0_read_data, 32'd50);

    // Write from p0 (both enables high means write), read back from p1.
    do_txn(0, 1'b1, 1'b1, 16'd7, 32'hDEAD, rd, err, lat);
    check("wr7_lat", lat, 3);
    check("wr7_err", err, 0);
    check("wr7_p0_rdata_kept", p0_read_data, 32'd50);
    do_txn(1, 1'b1, 1'b0, 16'd7, '0, rd, err, lat);
    check("rd7_lat", lat, 3);
    check("rd7_data", rd, 32'hDEAD);
    check("rd7_p0_rdata_kept", p0_read_data, 32'd50);

    // Watchdog: RAM never answers.
    ram_dead = 1'b1;
    do_txn(1, 1'b1, 1'b0, 16'd3, '0, rd, err, lat);
    ram_dead = 1'b0;
    check("to_lat", lat, TO + 2);
    check("to_err", err, 1);
    check("to_data", rd, 0);

    // Reset during WAIT: immediate clear, lost transaction never completes.
    ram_dead = 1'b1;
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 16'd4, '0);
    repeat (5) @(negedge clk);
    check("rstw_busy_before", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("rstw_busy", busy, 0);
    check("rstw_ram_re", ram_read_enable, 0);
    check("rstw_ram_addr", ram_address, 0);
    check("rstw_p1_rdata", p1_read_data, 0);
    set_req(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    rst = 1'b0;
    saw = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (p0_ready || p1_ready) saw = 1'b1;
    end
    check("rstw_no_ready", saw, 0);
    ram_dead = 1'b0;
    do_txn(0, 1'b1, 1'b0, 16'd9, '0, rd, err, lat);
    check("rstw_next_lat", lat, 3);
    check("rstw_next_data", rd, 32'd90);
    check("rstw_next_err", err, 0);

    // Randomized traffic. RAM contents were reinitialised by the reset above.
    for (int i = 0; i < 256; i++) model_mem[i] = DW'(i * 10);
    exp_rd[0] = 32'd90;
    exp_rd[1] = 32'd0;
    for (int p = 0; p < 2; p++) begin
      act[p] = 1'b0; rlat[p] = 0; gap[p] = 1; op_w[p] = 1'b0; ad[p] = '0; wd[p] = '0;
    end
    prev_en = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      cur_en = ram_read_enable | ram_write_enable;
      if (cur_en) check("rnd_en_single", prev_en, 0);
      prev_en = cur_en;
      for (int p = 0; p < 2; p++) begin
        rdy = (p == 0) ? p0_ready : p1_ready;
        if (act[p]) rlat[p]++;
        if (rdy) begin
          if (!act[p]) begin
            check("rnd_spurious_ready", rdy, 0);
          end else begin
            // Worst case: the other port was granted at the same edge our request arrived.
            check("rnd_lat_max", rlat[p] <= 7, 1);
            check("rnd_lat_min", rlat[p] >= 3, 1);
            check("rnd_err", (p == 0) ? p0_error : p1_error, 0);
            if (op_w[p]) model_mem[ad[p]] = wd[p];
            else exp_rd[p] = model_mem[ad[p]];
            check("rnd_rdata", (p == 0) ? p0_read_data : p1_read_data, exp_rd[p]);
            act[p] = 1'b0;
            gap[p] = $urandom_range(1, 3);
            set_req(p, 1'b0, 1'b0, '0, '0);
          end
        end else if (act[p] && rlat[p] > 30) begin
          check("rnd_hang", rlat[p], 7);
          act[p] = 1'b0;
          gap[p] = 1;
          set_req(p, 1'b0, 1'b0, '0, '0);
        end else if (!act[p]) begin
          if (gap[p] > 0) gap[p]--;
          else if (cyc < 1800 && $urandom_range(0, 1) == 1) begin
            r       = $urandom_range(0, 2);
            op_w[p] = (r != 0);
            ad[p]   = AW'($urandom_range(0, 31));
            wd[p]   = $urandom;
            set_req(p, r != 1, r != 0, ad[p], wd[p]);
            act[p]  = 1'b1;
            rlat[p] = 0;
          end
        end
      end
      if (cyc >= 1800 && !act[0] && !act[1]) break;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
